fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Fetch-stage PC generator directly upstream of the branch predictor. It owns the fetch PC register and presents the PC to the predictor. It takes the predicted next PC, hands {PC, predicted NPC} to the instruction fetch/decode path through a valid/ready handshake, and tracks in-flight predictions in an in-order queue. On in-order resolution it detects mispredicts, redirects fetch, and produces the predictor's training write (PC_actual / NPC_actual / is_taken_actual).

Parameters:
RESET_PC, 16'h0000, fetch PC loaded on reset
DEPTH, 4, in-flight prediction queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pred_pc  out  16  current fetch PC, to predictor read port
pred_npc  in  16  predictor's NPC for pred_pc (combinational, same cycle)
if_valid  out  1  fetch request valid
if_ready  in  1  downstream accepts fetch
if_pc  out  16  PC of offered fetch (= pred_pc)
if_npc_pred  out  16  predicted NPC of offered fetch (= pred_npc)
res_valid  in  1  oldest in-flight instruction resolved this cycle
res_npc  in  16  actual next PC of that instruction
redirect  out  1  mispredict flush, combinational in resolve cycle
redirect_pc  out  16  correct PC on redirect (= res_npc)
upd_valid  out  1  predictor training write valid (registered)
upd_pc  out  16  to predictor PC_actual
upd_npc  out  16  to predictor NPC_actual
upd_taken  out  1  to predictor is_taken_actual
q_count  out  log2(DEPTH)+1  in-flight entries
mispredict_cnt  out  16  saturating mispredict counter

Behaviour:
- Reset is synchronous, evaluated at the clock edge while rst=1. After reset: pc=RESET_PC, queue empty, q_count=0, upd_valid=0, upd_pc=0, upd_npc=0, upd_taken=0, mispredict_cnt=0.
- if_valid=0 in any cycle where rst=1.
- pred_pc = if_pc = pc register. if_npc_pred = pred_npc.
- if_valid = !rst && (q_count<DEPTH) && !redirect.
- Fetch transfer occurs when if_valid && if_ready. It pushes {pc, pred_npc} into the queue. Next cycle, pc = pred_npc.
- With no transfer and no redirect, pc holds.
- Resolve: res_valid pops the oldest entry {e_pc, e_npc}. res_valid with an empty queue is ignored: no pop, no update, no redirect.
- taken = (res_npc != e_pc+4). The add is 16-bit modulo: 16'hFFFC+4 = 16'h0000.
- mispredict = (res_npc != e_npc).
- On mispredict:
  - redirect=1 and redirect_pc=res_npc in the same cycle, which forces if_valid=0.
  - Next cycle: pc=res_npc, queue fully cleared (q_count=0), mispredict_cnt increments and saturates at 16'hFFFF.
- Otherwise redirect=0 and redirect_pc=0.
- Simultaneous push and pop without mispredict: both happen and q_count is unchanged. This is legal at any count below DEPTH. At q_count=DEPTH no push is possible.
- Training write, registered, one cycle after a valid pop: upd_valid=1, upd_pc=e_pc, upd_npc=res_npc, upd_taken=taken.
- In all other cycles: upd_valid=0, upd_taken=0, upd_pc=0, upd_npc=0. The predictor's BTB write is therefore never spuriously enabled.
- Queue is a circular buffer with wrapping read/write pointers. A clear resets both pointers.
- Reset mid-operation overrides any same-cycle push, pop, or redirect. A pending training write is dropped.

Test Plan:
1. Streaming fill: RESET_PC=0, pred_npc=pred_pc+4, if_ready=1, no resolves. Required: if_pc 0x0000, 0x0004, 0x0008, 0x000C on consecutive cycles; then q_count=4, if_valid=0, pc holds at 0x0010.
2. Correct not-taken resolve: queue head {0x0000, 0x0004}, res_valid with res_npc=0x0004. Required: redirect=0; next cycle upd_valid=1, upd_pc=0x0000, upd_npc=0x0004, upd_taken=0; q_count drops by 1 unless a push occurs the same cycle.
3. Mispredict: head {0x0010, 0x0014}, three more entries queued, res_npc=0x0040, if_ready=1. Required in the same cycle: redirect=1, redirect_pc=0x0040, if_valid=0. Next cycle: if_pc=0x0040, q_count=0, upd_taken=1, upd_npc=0x0040, mispredict_cnt=1.
4. Backpressure with concurrent pop: if_ready=0 for 3 cycles at pc=0x0020 while a correct resolve pops. Required: if_pc stays 0x0020, no push, q_count decrements once. When if_ready returns, 0x0020 transfers exactly once.
5. Wrap-around: entry {0xFFFC, 0x0000}, res_npc=0x0000. Required: no redirect, upd_taken=0. Also res_valid with an empty queue produces no update and no count change.
6. Reset mid-operation: full queue plus a pending mispredict, rst=1 for 1 cycle. Required after reset: pc=RESET_PC, q_count=0, upd_valid=0, mispredict_cnt=0, redirect=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: owns the fetch PC, offers {pc, predicted npc} downstream,
// tracks in-flight predictions in order and produces redirect and predictor training writes.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [15:0]              pred_pc,
    input  logic [15:0]              pred_npc,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [15:0]              if_pc,
    output logic [15:0]              if_npc_pred,
    input  logic                     res_valid,
    input  logic [15:0]              res_npc,
    output logic                     redirect,
    output logic [15:0]              redirect_pc,
    output logic                     upd_valid,
    output logic [15:0]              upd_pc,
    output logic [15:0]              upd_npc,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [15:0]              mispredict_cnt
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] q_pc  [DEPTH];
    logic [XLEN-1:0] q_npc [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_npc;
    logic            pop;
    logic            push;
    logic            mispredict;
    logic            taken;

    assign pred_pc     = pc;
    assign if_pc       = pc;
    assign if_npc_pred = pred_npc;
    assign q_count     = count;

    // Resolve compare against the queue head; reset suppresses any same-cycle flush.
    always_comb begin
        head_pc     = q_pc[rd_ptr];
        head_npc    = q_npc[rd_ptr];
        pop         = res_valid && (count != '0);
        mispredict  = !rst && pop && (res_npc != head_npc);
        taken       = (res_npc != (head_pc + XLEN'(4)));
        redirect    = mispredict;
        redirect_pc = mispredict ? res_npc : '0;
        if_valid    = !rst && (count < CW'(DEPTH)) && !mispredict;
        push        = if_valid && if_ready;
        count_nxt   = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Payload storage; push is never asserted alongside a flush or reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= pc;
            q_npc[wr_ptr] <= pred_npc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_npc        <= '0;
            upd_taken      <= 1'b0;
            mispredict_cnt <= '0;
        end else begin
            // Training write mirrors every valid pop, including the mispredicting one.
            upd_valid <= pop;
            upd_pc    <= pop ? head_pc : '0;
            upd_npc   <= pop ? res_npc : '0;
            upd_taken <= pop && taken;
            if (mispredict) begin
                pc     <= res_npc;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                if (mispredict_cnt != 16'hFFFF) begin
                    mispredict_cnt <= mispredict_cnt + 16'd1;
                end
            end else begin
                if (push) begin
                    pc     <= pred_npc;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_fetch_pc_unit;

    localparam int DEPTH = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pred_pc;
    logic [15:0] pred_npc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_pc;
    logic [15:0] if_npc_pred;
    logic        res_valid;
    logic [15:0] res_npc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [15:0] upd_npc;
    logic        upd_taken;
    logic [2:0]  q_count;
    logic [15:0] mispredict_cnt;

    logic        npc_mode;
    logic [15:0] npc_fixed;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Predictor stand-in: sequential by default, or a forced target.
    assign pred_npc = npc_mode ? npc_fixed : (pred_pc + 16'd4);

    fetch_pc_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .pred_pc(pred_pc), .pred_npc(pred_npc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_npc_pred(if_npc_pred),
        .res_valid(res_valid), .res_npc(res_npc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_npc(upd_npc), .upd_taken(upd_taken),
        .q_count(q_count), .mispredict_cnt(mispredict_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: in-flight entries as a plain queue, outputs derived from the rules.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] npc;
    } ent_t;

    ent_t        mq[$];
    ent_t        e_head;
    logic [15:0] m_pc;
    logic        m_upd_valid;
    logic [15:0] m_upd_pc;
    logic [15:0] m_upd_npc;
    logic        m_upd_taken;
    logic [15:0] m_cnt;
    logic        m_known = 1'b0;
    logic        e_pop;
    logic        e_mis;
    logic        e_ifv;

    always @(negedge clk) begin
        e_pop  = !rst && res_valid && (mq.size() != 0);
        e_head = e_pop ? mq[0] : '0;
        e_mis  = e_pop && (res_npc != e_head.npc);
        e_ifv  = !rst && (mq.size() < DEPTH) && !e_mis;
        if (rst) begin
            chk("m_rst_if_valid", 32'(if_valid), 32'(0));
            chk("m_rst_redirect", 32'(redirect), 32'(0));
        end
        if (m_known) begin
            chk("m_pred_pc",     32'(pred_pc),        32'(m_pc));
            chk("m_if_pc",       32'(if_pc),          32'(m_pc));
            chk("m_if_npc_pred", 32'(if_npc_pred),    32'(pred_npc));
            chk("m_if_valid",    32'(if_valid),       32'(e_ifv));
            chk("m_redirect",    32'(redirect),       32'(e_mis));
            chk("m_redirect_pc", 32'(redirect_pc),    32'(e_mis ? res_npc : 16'h0));
            chk("m_upd_valid",   32'(upd_valid),      32'(m_upd_valid));
            chk("m_upd_pc",      32'(upd_pc),         32'(m_upd_pc));
            chk("m_upd_npc",     32'(upd_npc),        32'(m_upd_npc));
            chk("m_upd_taken",   32'(upd_taken),      32'(m_upd_taken));
            chk("m_q_count",     32'(q_count),        32'(mq.size()));
            chk("m_mis_cnt",     32'(mispredict_cnt), 32'(m_cnt));
        end
        if (rst) begin
            m_pc = RST_PC; mq.delete();
            m_upd_valid = 1'b0; m_upd_pc = '0; m_upd_npc = '0; m_upd_taken = 1'b0;
            m_cnt = '0; m_known = 1'b1;
        end else if (m_known) begin
            m_upd_valid = e_pop;
            m_upd_pc    = e_pop ? e_head.pc : 16'h0;
            m_upd_npc   = e_pop ? res_npc : 16'h0;
            m_upd_taken = e_pop && (res_npc != 16'(e_head.pc + 16'd4));
            if (e_mis) begin
                m_pc = res_npc;
                mq.delete();
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                if (e_pop) void'(mq.pop_front());
                if (e_ifv && if_ready) begin
                    mq.push_back({m_pc, pred_npc});
                    m_pc = pred_npc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; if_ready = 1'b0; res_valid = 1'b0; res_npc = '0;
        npc_mode = 1'b0; npc_fixed = '0;
        #1;
        @(negedge clk);
        chk("rst_if_valid", 32'(if_valid), 32'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pc",      32'(if_pc),          32'h0000);
        chk("reset_q",       32'(q_count),        32'd0);
        chk("reset_upd_v",   32'(upd_valid),      32'd0);
        chk("reset_upd_pc",  32'(upd_pc),         32'd0);
        chk("reset_upd_npc", 32'(upd_npc),        32'd0);
        chk("reset_upd_tk",  32'(upd_taken),      32'd0);
        chk("reset_cnt",     32'(mispredict_cnt), 32'd0);
        tick();

        // Streaming fill
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_if_pc",    32'(if_pc),    32'(4 * i));
            chk("t1_if_valid", 32'(if_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("t1_full_q",  32'(q_count),  32'd4);
        chk("t1_full_v",  32'(if_valid), 32'd0);
        chk("t1_full_pc", 32'(if_pc),    32'h0010);
        tick();
        @(negedge clk);
        chk("t1_hold_pc", 32'(if_pc), 32'h0010);
        tick();

        // Correct not-taken resolve, then pops overlapped with pushes
        if_ready = 1'b0; res_valid = 1'b1; res_npc = 16'h0004;
        @(negedge clk);
        chk("t2_redirect", 32'(redirect), 32'd0);
        tick();
        res_npc = 16'h0008; if_ready = 1'b1;
        @(negedge clk);
        chk("t2_upd_v",   32'(upd_valid), 32'd1);
        chk("t2_upd_pc",  32'(upd_pc),    32'h0000);
        chk("t2_upd_npc", 32'(upd_npc),   32'h0004);
        chk("t2_upd_tk",  32'(upd_taken), 32'd0);
        chk("t2_q",       32'(q_count),   32'd3);
        tick();
        res_npc = 16'h000C;
        @(negedge clk);
        chk("t2_pushpop_q", 32'(q_count), 32'd3);
        chk("t2_upd_pc2",   32'(upd_pc),  32'h0004);
        tick();
        res_npc = 16'h0010;
        tick();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t2_pc_1c", 32'(if_pc), 32'h001C);
        tick();

        // Mispredict on head {0x10, 0x14} with three more entries
        res_valid = 1'b1; res_npc = 16'h0040;
        @(negedge clk);
        chk("t3_q_full",    32'(q_count),     32'd4);
        chk("t3_redirect",  32'(redirect),    32'd1);
        chk("t3_redir_pc",  32'(redirect_pc), 32'h0040);
        chk("t3_if_valid",  32'(if_valid),    32'd0);
        tick();
        res_valid = 1'b0; npc_mode = 1'b1; npc_fixed = 16'h0020;
        @(negedge clk);
        chk("t3_pc",      32'(if_pc),          32'h0040);
        chk("t3_q",       32'(q_count),        32'd0);
        chk("t3_upd_tk",  32'(upd_taken),      32'd1);
        chk("t3_upd_npc", 32'(upd_npc),        32'h0040);
        chk("t3_upd_pc",  32'(upd_pc),         32'h0010);
        chk("t3_cnt",     32'(mispredict_cnt), 32'd1);
        tick();

        // Backpressure at 0x20 while the head resolves correctly
        if_ready = 1'b0; npc_mode = 1'b0; res_valid = 1'b1; res_npc = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_pc", 32'(if_pc), 32'h0020);
            if (i == 1) begin
                chk("t4_q_dec",   32'(q_count),   32'd0);
                chk("t4_upd_tk",  32'(upd_taken), 32'd1);
                chk("t4_upd_pc",  32'(upd_pc),    32'h0040);
            end
            tick();
            res_valid = 1'b0;
        end
        if_ready = 1'b1;
        @(negedge clk);
        chk("t4_xfer_npc", 32'(if_npc_pred), 32'h0024);
        tick();
        if_ready = 1'b0;
        @(negedge clk);
        chk("t4_once_pc", 32'(if_pc),   32'h0024);
        chk("t4_once_q",  32'(q_count), 32'd1);
        tick();

        // Wrap-around entry {0xFFFC, 0x0000} and resolve on empty queue
        res_valid = 1'b1; res_npc = 16'h0024;
        tick();
        res_valid = 1'b0; if_ready = 1'b1;
        tick();
        if_ready = 1'b0; res_valid = 1'b1; res_npc = 16'hFFFC;
        @(negedge clk);
        chk("t5_redir_pc", 32'(redirect_pc), 32'hFFFC);
        tick();
        res_valid = 1'b0; if_ready = 1'b1;
        @(negedge clk);
        chk("t5_pc_fffc",  32'(if_pc),       32'hFFFC);
        chk("t5_npc_wrap", 32'(if_npc_pred), 32'h0000);
        tick();
        if_ready = 1'b0; res_valid = 1'b1; res_npc = 16'h0000;
        @(negedge clk);
        chk("t5_no_redirect", 32'(redirect), 32'd0);
        tick();
        res_npc = 16'h1234;
        @(negedge clk);
        chk("t5_upd_pc",  32'(upd_pc),    32'hFFFC);
        chk("t5_upd_npc", 32'(upd_npc),   32'h0000);
        chk("t5_upd_tk",  32'(upd_taken), 32'd0);
        chk("t5_empty_redirect", 32'(redirect), 32'd0);
        tick();
        res_valid = 1'b0;
        @(negedge clk);
        chk("t5_empty_upd_v", 32'(upd_valid),      32'd0);
        chk("t5_empty_q",     32'(q_count),        32'd0);
        chk("t5_cnt",         32'(mispredict_cnt), 32'd2);
        tick();

        // Reset mid-operation with a full queue and a pending mispredict
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; res_valid = 1'b1; res_npc = 16'h0099;
        @(negedge clk);
        chk("t6_q_full",   32'(q_count),  32'd4);
        chk("t6_if_valid", 32'(if_valid), 32'd0);
        tick();
        rst = 1'b0; res_valid = 1'b0; if_ready = 1'b0;
        @(negedge clk);
        chk("t6_pc",       32'(if_pc),          32'(RST_PC));
        chk("t6_q",        32'(q_count),        32'd0);
        chk("t6_upd_v",    32'(upd_valid),      32'd0);
        chk("t6_cnt",      32'(mispredict_cnt), 32'd0);
        chk("t6_redirect", 32'(redirect),       32'd0);
        tick();
        if_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
